// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one memory port; one outstanding access, reads return after RD_LAT+1, writes/errors after 2 cycles.
// Backpressure: grants only while idle, so requesters hold req until gnt; data wins contention until fetch has been starved STARVE_MAX times.
module mem_port_arbiter #(
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [63:0] i_addr,
    output logic        i_gnt,
    output logic        i_valid,
    output logic        i_err,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic        d_err,
    output logic [63:0] d_rdata,
    output logic [63:0] mem_raddress,
    output logic [63:0] mem_waddress,
    output logic [63:0] mem_datain,
    output logic        mem_wr,
    input  logic [63:0] mem_dataout,
    output logic        busy
);
    localparam logic [2:0] LP_RD_LAT = 3'(RD_LAT);
    localparam logic [2:0] LP_STARVE = 3'(STARVE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR, S_ERR} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_starve, r_cnt;
    logic        r_is_fetch, r_sel_hi;
    logic [63:0] r_raddr, r_waddr, r_wdata;
    logic        r_i_valid, r_i_err, r_d_valid, r_d_err;
    logic [31:0] r_i_rdata;
    logic [63:0] r_d_rdata;
    logic        w_idle, w_i_win, w_d_win, w_misalign, w_wr;

    always_comb begin
        w_idle      = (r_state == S_IDLE) && !reset;
        w_i_win     = w_idle && i_req && (!d_req || (r_starve == LP_STARVE));
        w_d_win     = w_idle && d_req && !w_i_win;
        w_misalign  = w_i_win ? (i_addr[1:0] != 2'b00) : (d_addr[2:0] != 3'b000);
        w_wr        = w_d_win && d_we;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_i_win || w_d_win) begin
                    if (w_misalign)  w_state_nxt = S_ERR;
                    else if (w_wr)   w_state_nxt = S_WR;
                    else             w_state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: if (r_cnt == LP_RD_LAT) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_starve   <= '0;
            r_cnt      <= '0;
            r_is_fetch <= 1'b0;
            r_sel_hi   <= 1'b0;
            r_raddr    <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_i_valid  <= 1'b0;
            r_i_err    <= 1'b0;
            r_d_valid  <= 1'b0;
            r_d_err    <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_i_valid <= 1'b0;
            r_i_err   <= 1'b0;
            r_d_valid <= 1'b0;
            r_d_err   <= 1'b0;

            if (w_i_win)
                r_starve <= '0;
            else if (w_d_win && i_req && (r_starve != LP_STARVE))
                r_starve <= r_starve + 3'd1;

            // Misaligned accesses never touch the memory-facing registers.
            if (w_i_win || w_d_win) begin
                r_is_fetch <= w_i_win;
                r_sel_hi   <= i_addr[2];
                r_cnt      <= 3'd1;
                if (!w_misalign) begin
                    if (w_wr) begin
                        r_waddr <= d_addr;
                        r_wdata <= d_wdata;
                    end else begin
                        r_raddr <= w_i_win ? i_addr : d_addr;
                    end
                end
            end

            case (r_state)
                S_RD_WAIT: begin
                    if (r_cnt == LP_RD_LAT) begin
                        if (r_is_fetch) begin
                            r_i_valid <= 1'b1;
                            r_i_rdata <= r_sel_hi ? mem_dataout[63:32] : mem_dataout[31:0];
                        end else begin
                            r_d_valid <= 1'b1;
                            r_d_rdata <= mem_dataout;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_WR: begin
                    r_d_valid <= 1'b1;
                    r_d_rdata <= '0;
                end
                S_ERR: begin
                    if (r_is_fetch) begin
                        r_i_valid <= 1'b1;
                        r_i_err   <= 1'b1;
                        r_i_rdata <= '0;
                    end else begin
                        r_d_valid <= 1'b1;
                        r_d_err   <= 1'b1;
                        r_d_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i_gnt        = w_i_win;
    assign d_gnt        = w_d_win;
    assign i_valid      = r_i_valid;
    assign i_err        = r_i_err;
    assign i_rdata      = r_i_rdata;
    assign d_valid      = r_d_valid;
    assign d_err        = r_d_err;
    assign d_rdata      = r_d_rdata;
    assign mem_raddress = r_raddr;
    assign mem_waddress = r_waddr;
    assign mem_datain   = r_wdata;
    assign mem_wr       = (r_state == S_WR);
    assign busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of grants, completions and memory traffic.
module tb_mem_port_arbiter;
    localparam int RD_LAT = 2;
    localparam int SMAX   = 4;
    localparam int N_CONTEND = 40;
    localparam int N_CYC     = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_gnt, i_valid, i_err;
    logic [63:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_req, d_we, d_gnt, d_valid, d_err;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic [63:0] mem_raddress, mem_waddress, mem_datain, mem_dataout;
    logic        mem_wr, busy;

    int cyc = 0;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Memory returns a value tied to both address and cycle, so a wrong capture cycle shows up.
    function automatic logic [63:0] memfn(input logic [63:0] a, input int c);
        logic [31:0] cu;
        cu = 32'(c);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ {cu, ~cu};
    endfunction

    assign mem_dataout = memfn(mem_raddress, cyc);

    mem_port_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_valid(d_valid), .d_err(d_err), .d_rdata(d_rdata),
        .mem_raddress(mem_raddress), .mem_waddress(mem_waddress), .mem_datain(mem_datain),
        .mem_wr(mem_wr), .mem_dataout(mem_dataout), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd_addr(input bit fetch, input bit mis);
        logic [63:0] a;
        a = {$urandom, $urandom};
        if (fetch) a[1:0] = mis ? 2'($urandom_range(1, 3)) : 2'b00;
        else       a[2:0] = mis ? 3'($urandom_range(1, 7)) : 3'b000;
        return a;
    endfunction

    // Transaction-level model state
    int          free_cyc = 0, cmp_cyc = -1, wr_cyc = -1, starve = 0;
    bit          cmp_fetch, cmp_err;
    logic [63:0] cmp_data, wr_addr, wr_data;
    logic [63:0] e_raddr = '0, e_waddr = '0, e_wdata = '0, e_d_rdata = '0;
    logic [31:0] e_i_rdata = '0;
    bit          i_taken = 0, d_taken = 0;
    int          nseq = 0;
    logic [9:0]  pat = 10'b1000010000;

    initial begin
        bit e_ig, e_dg, e_iv, e_dv, e_ie, e_de, contend, mis;
        logic [63:0] a, word;
        reset = 1'b1; i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        for (int k = 0; k < N_CONTEND + N_CYC; k++) begin
            @(posedge clk); #1;
            cyc++;
            contend = (k < N_CONTEND);
            if (i_taken) begin i_req = 0; i_taken = 0; end
            if (d_taken) begin d_req = 0; d_taken = 0; end
            reset = (k < 2) || (!contend && $urandom_range(0, 49) == 0);
            if (k >= 2 && !i_req && (contend || $urandom_range(0, 99) < 30)) begin
                i_req  = 1;
                i_addr = rnd_addr(1, !contend && $urandom_range(0, 99) < 15);
            end
            if (k >= 2 && !d_req && (contend || $urandom_range(0, 99) < 30)) begin
                d_req   = 1;
                d_we    = contend ? 1'b0 : 1'($urandom_range(0, 1));
                d_addr  = rnd_addr(0, !contend && $urandom_range(0, 99) < 15);
                d_wdata = {$urandom, $urandom};
            end

            @(negedge clk);
            e_ig = 0; e_dg = 0;
            if (!reset && cyc >= free_cyc) begin
                if (i_req && (!d_req || starve == SMAX)) e_ig = 1;
                else if (d_req)                         e_dg = 1;
            end
            e_iv = (cyc == cmp_cyc) && cmp_fetch;
            e_dv = (cyc == cmp_cyc) && !cmp_fetch;
            e_ie = e_iv && cmp_err;
            e_de = e_dv && cmp_err;
            if (e_iv) e_i_rdata = cmp_data[31:0];
            if (e_dv) e_d_rdata = cmp_data;

            chk("i_gnt", 64'(i_gnt), 64'(e_ig));
            chk("d_gnt", 64'(d_gnt), 64'(e_dg));
            chk("i_valid", 64'(i_valid), 64'(e_iv));
            chk("d_valid", 64'(d_valid), 64'(e_dv));
            chk("i_err", 64'(i_err), 64'(e_ie));
            chk("d_err", 64'(d_err), 64'(e_de));
            chk("i_rdata", 64'(i_rdata), 64'(e_i_rdata));
            chk("d_rdata", d_rdata, e_d_rdata);
            chk("busy", 64'(busy), 64'(cyc < free_cyc));
            chk("mem_wr", 64'(mem_wr), 64'(cyc == wr_cyc));
            chk("mem_raddress", mem_raddress, e_raddr);
            chk("mem_waddress", mem_waddress, e_waddr);
            chk("mem_datain", mem_datain, e_wdata);
            if (contend && (i_gnt || d_gnt) && nseq < 10) begin
                chk("contend_seq", 64'(i_gnt), 64'(pat[nseq]));
                nseq++;
            end

            if (reset) begin
                free_cyc = cyc + 1; cmp_cyc = -1; wr_cyc = -1; starve = 0;
                e_raddr = '0; e_waddr = '0; e_wdata = '0; e_i_rdata = '0; e_d_rdata = '0;
            end else if (e_ig || e_dg) begin
                if (e_ig) starve = 0;
                else if (i_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
                a   = e_ig ? i_addr : d_addr;
                mis = e_ig ? (i_addr[1:0] != 0) : (d_addr[2:0] != 0);
                cmp_fetch = e_ig;
                if (mis) begin
                    cmp_cyc = cyc + 2; cmp_err = 1; cmp_data = '0; free_cyc = cyc + 2;
                end else if (e_dg && d_we) begin
                    wr_cyc = cyc + 1; e_waddr = d_addr; e_wdata = d_wdata;
                    cmp_cyc = cyc + 2; cmp_err = 0; cmp_data = '0; free_cyc = cyc + 2;
                end else begin
                    e_raddr  = a;
                    word     = memfn(a, cyc + RD_LAT);
                    cmp_data = e_ig ? {32'h0, (a[2] ? word[63:32] : word[31:0])} : word;
                    cmp_cyc  = cyc + RD_LAT + 1; cmp_err = 0; free_cyc = cyc + RD_LAT + 1;
                end
                if (e_ig) i_taken = 1; else d_taken = 1;
            end
        end
        chk("contend_grants_seen", 64'(nseq), 64'd10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
